ram_write_driver: RTL and testbench

- Write-back sequencer for the neural layer datapath; the opposite direction of the weight-load read driver.
- After a layer's units finish summing, it selects each unit output in turn and captures it.
- Each captured value is written to RAM at a layer-dependent base address; a single-cycle done pulse follows.
- Sits between the unit output mux and the shared RAM write port.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/ram_write_driver_if.sv | 28 ++
 rtl/ram_write_driver.sv | 98 +++++++++
 tb/tb_ram_write_driver.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural layer datapath: default sizes, the
// write-back sequencer state encoding and a reusable ReLU helper.
package nn_pkg;

  localparam int NUM_UNITS_D    = 4;
  localparam int DATA_W_D       = 16;
  localparam int ADDR_W_D       = 32;
  localparam int LAYER_STRIDE_D = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_STALL   = 3'd4,
    S_DONE    = 3'd5
  } wr_state_e;

  // Clamp negative two's-complement values to zero.
  function automatic logic [DATA_W_D-1:0] relu(input logic [DATA_W_D-1:0] x);
    return x[DATA_W_D-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/ram_write_driver_if.sv
// Bundle between the write-back sequencer, the unit output mux and the
// shared RAM write port; master is the sequencer side.
interface ram_write_driver_if #(
  parameter int DATA_W = nn_pkg::DATA_W_D,
  parameter int ADDR_W = nn_pkg::ADDR_W_D
) ();

  logic              start;
  logic [1:0]        layer;
  logic [2:0]        unit_sel;
  logic [DATA_W-1:0] unit_data;
  logic [ADDR_W-1:0] RAM_address;
  logic [DATA_W-1:0] RAM_wdata;
  logic              RAM_we;
  logic              busy;
  logic              done;

  modport master (
    input  start, layer, unit_data,
    output unit_sel, RAM_address, RAM_wdata, RAM_we, busy, done
  );

  modport slave (
    output start, layer, unit_data,
    input  unit_sel, RAM_address, RAM_wdata, RAM_we, busy, done
  );

endinterface

// File: rtl/ram_write_driver.sv
// Write-back sequencer: walks every unit output of a layer and writes it to RAM
// at layer*LAYER_STRIDE. Define RAM_WRITE_RELU_EN to apply ReLU on capture.
module ram_write_driver
  import nn_pkg::*;
#(
  parameter int NUM_UNITS    = NUM_UNITS_D,
  parameter int DATA_W       = DATA_W_D,
  parameter int ADDR_W       = ADDR_W_D,
  parameter int LAYER_STRIDE = LAYER_STRIDE_D
) (
  input  logic                clk,
  input  logic                reset,
  ram_write_driver_if.master  bus
);

  wr_state_e         r_state;
  logic [2:0]        r_unit_sel;
  logic [2:0]        r_count;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_base;
  logic [DATA_W-1:0] w_capture;
  logic              w_last;

  assign w_base = ADDR_W'(bus.layer) * ADDR_W'(LAYER_STRIDE);
  assign w_last = (r_count == 3'(NUM_UNITS - 1));

`ifdef RAM_WRITE_RELU_EN
  assign w_capture = bus.unit_data[DATA_W-1] ? '0 : bus.unit_data;
`else
  assign w_capture = bus.unit_data;
`endif

  // Outputs lag the state by one edge, so the write strobe is visible during STALL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_unit_sel <= '0;
      r_count    <= '0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_address  <= w_base;
            r_unit_sel <= '0;
            r_count    <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_SELECT;
          end
        end
        S_SELECT: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_wdata <= w_capture;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_we    <= 1'b1;
          r_state <= S_STALL;
        end
        S_STALL: begin
          r_we <= 1'b0;
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_unit_sel <= r_unit_sel + 3'd1;
            r_address  <= r_address + ADDR_W'(1);
            r_count    <= r_count + 3'd1;
            r_state    <= S_SELECT;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.unit_sel    = r_unit_sel;
  assign bus.RAM_address = r_address;
  assign bus.RAM_wdata   = r_wdata;
  assign bus.RAM_we      = r_we;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_ram_write_driver.sv
// Scoreboard bench for ram_write_driver: stimulus queues the expected writes and
// done pulse per run, an independent negedge monitor pops and compares them.
module tb_ram_write_driver;

  localparam int N      = 4;
  localparam int DW     = 16;
  localparam int AW     = 32;
  localparam int STRIDE = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_write_driver_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_write_driver #(
    .NUM_UNITS(N), .DATA_W(DW), .ADDR_W(AW), .LAYER_STRIDE(STRIDE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit     is_done;
    longint addr;
    longint data;
    int     cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   free_at = 0;
  logic signed [DW-1:0] vals [8];

  // Unit output mux: one cycle of latency after unit_sel.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.unit_data <= vals[bus.unit_sel];
  end

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic longint model_data(input int v);
`ifdef RAM_WRITE_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected behaviour of one run whose start is sampled on edge k.
  task automatic push_run(input int k, input int lay);
    for (int u = 0; u < N; u++) begin
      exp_t e;
      e.is_done = 1'b0;
      e.addr    = (longint'(lay) * STRIDE + u) & 64'hFFFF_FFFF;
      e.data    = model_data(int'(vals[u]));
      e.cyc     = k + 3 + 4 * u;
      exp_q.push_back(e);
    end
    begin
      exp_t d;
      d.is_done = 1'b1;
      d.addr    = 0;
      d.data    = 0;
      d.cyc     = k + 4 * N;
      exp_q.push_back(d);
    end
    busy_lo = k;
    busy_hi = k + 4 * N;
    free_at = k + 4 * N + 2;
  endtask

  task automatic wait_idle();
    while (cyc + 1 < free_at) tick();
  endtask

  task automatic start_run(input int lay, output int k);
    wait_idle();
    bus.layer = 2'(lay);
    bus.start = 1'b1;
    k = cyc + 1;
    push_run(k, lay);
    tick();
    bus.start = 1'b0;
    $display("run: layer=%0d start_edge=%0d vals=%0d,%0d,%0d,%0d", lay, k,
             vals[0], vals[1], vals[2], vals[3]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_unit_sel"}, bus.unit_sel, 0);
    check({tag, "_addr"}, bus.RAM_address, 0);
    check({tag, "_wdata"}, bus.RAM_wdata, 0);
    check({tag, "_we"}, bus.RAM_we, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  // Monitor: compares every strobe against the scoreboard, and busy every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        if (bus.RAM_we === 1'b1 || bus.done === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", bus.RAM_we | bus.done, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_kind_done", bus.done, e.is_done);
            check("strobe_cycle", cyc, e.cyc);
            if (!e.is_done) begin
              check("wr_addr", bus.RAM_address, e.addr);
              check("wr_data", $signed(bus.RAM_wdata), e.data);
              $display("write: cyc=%0d addr=%0d data=%0d", cyc, bus.RAM_address,
                       $signed(bus.RAM_wdata));
            end else begin
              $display("done: cyc=%0d", cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bus.start = 1'b0;
    bus.layer = 2'd0;
    for (int i = 0; i < 8; i++) vals[i] = '0;

    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Directed run: layer 0, mixed-sign data.
    vals[0] = 16'sd5; vals[1] = -16'sd3; vals[2] = 16'sd7; vals[3] = 16'sd100;
    start_run(0, k);
    wait_idle();

    // Layer 2, then a layer change mid-run must be ignored.
    start_run(2, k);
    repeat (5) tick();
    bus.layer = 2'd1;
    wait_idle();

    // start re-pulsed while busy.
    vals[0] = -16'sd1; vals[1] = 16'sd32767; vals[2] = -16'sd32768; vals[3] = 16'sd0;
    start_run(1, k);
    while (cyc + 1 < k + 6) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle();

    // Reset in the cycle after the second write strobe.
    start_run(3, k);
    while (cyc < k + 8) tick();
    reset = 1'b1;
    exp_q.delete();
    busy_hi = cyc;
    free_at = 0;
    tick();
    check_zero("midrun_reset");
    $display("reset: applied mid-run at cycle %0d", cyc);
    reset = 1'b0;
    repeat (4) tick();
    start_run(3, k);
    wait_idle();

    // start held high: back-to-back runs every 4N+2 edges.
    vals[0] = 16'sd11; vals[1] = -16'sd22; vals[2] = 16'sd33; vals[3] = -16'sd44;
    bus.layer = 2'd1;
    bus.start = 1'b1;
    k = cyc + 1;
    for (int r = 0; r < 3; r++) begin
      push_run(k, 1);
      $display("run: held start layer=1 start_edge=%0d", k);
      if (r == 2) begin
        tick();
        bus.start = 1'b0;
      end
      while (cyc < k + 4 * N + 1) tick();
      k = cyc + 1;
    end
    wait_idle();

    // Randomised runs with spurious starts and layer churn while busy.
    for (int it = 0; it < 20; it++) begin
      int lay;
      int p;
      for (int u = 0; u < N; u++) vals[u] = DW'($urandom_range(0, 65535));
      lay = int'($urandom_range(0, 3));
      start_run(lay, k);
      p = int'($urandom_range(1, 4 * N + 1));
      while (cyc + 1 < k + p) begin
        bus.layer = 2'($urandom_range(0, 3));
        tick();
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_idle();
      repeat (int'($urandom_range(0, 2))) tick();
    end

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
